// File: rtl/clock_calendar.sv
// clock_calendar: 1 Hz time-of-day and date counter with per-field edit increments.
module clock_calendar (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [2:0] mode,
  input  logic       inc_btn,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year_lo,
  output logic [6:0] year_hi,
  output logic       leap
);
  function automatic logic is_leap(input logic [6:0] lo, input logic [1:0] hi);
    return (lo != 7'd0 && lo[1:0] == 2'd0) || (lo == 7'd0 && hi == 2'd0);
  endfunction
  function automatic logic [4:0] dim_of(input logic [3:0] m, input logic l);
    return (m == 4'd2) ? (l ? 5'd29 : 5'd28) :
           (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
  endfunction
  logic s1, s2, s3, inc_pulse;
  logic c_s, c_m, c_h, c_d, c_mo, c_y;
  logic [5:0] sec_inc, min_inc, n_sec, n_min;
  logic [4:0] hour_inc, day_inc, dim, dim_mo, dim_ylo, dim_yhi, n_hour, n_day;
  logic [3:0] mo_inc, n_month;
  logic [6:0] ylo_inc, yhi_inc, n_ylo, n_yhi;
  assign inc_pulse = s2 & ~s3;
  assign leap      = is_leap(year_lo, year_hi[1:0]);
  assign dim       = dim_of(month, leap);
  assign c_s  = sec == 6'd59;
  assign c_m  = c_s && min == 6'd59;
  assign c_h  = c_m && hour == 5'd23;
  assign c_d  = c_h && day == dim;
  assign c_mo = c_d && month == 4'd12;
  assign c_y  = c_mo && year_lo == 7'd99;
  assign sec_inc  = (sec == 6'd59) ? 6'd0 : sec + 6'd1;
  assign min_inc  = (min == 6'd59) ? 6'd0 : min + 6'd1;
  assign hour_inc = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
  assign day_inc  = (day == dim) ? 5'd1 : day + 5'd1;
  assign mo_inc   = (month == 4'd12) ? 4'd1 : month + 4'd1;
  assign ylo_inc  = (year_lo == 7'd99) ? 7'd0 : year_lo + 7'd1;
  assign yhi_inc  = (year_hi == 7'd99) ? 7'd0 : year_hi + 7'd1;
  // month length after the edit, used to clamp day in the same update
  assign dim_mo  = dim_of(mo_inc, leap);
  assign dim_ylo = dim_of(month, is_leap(ylo_inc, year_hi[1:0]));
  assign dim_yhi = dim_of(month, is_leap(year_lo, yhi_inc[1:0]));
  always_comb begin
    n_sec   = sec;
    n_min   = min;
    n_hour  = hour;
    n_day   = day;
    n_month = month;
    n_ylo   = year_lo;
    n_yhi   = year_hi;
    if (mode == 3'd0) begin
      if (tick_1hz) begin
        n_sec = sec_inc;
        if (c_s) n_min = min_inc;
        if (c_m) n_hour = hour_inc;
        if (c_h) n_day = day_inc;
        if (c_d) n_month = mo_inc;
        if (c_mo) n_ylo = ylo_inc;
        if (c_y) n_yhi = yhi_inc;
      end
    end else if (inc_pulse) begin
      case (mode)
        3'd1: n_sec = sec_inc;
        3'd2: n_min = min_inc;
        3'd3: n_hour = hour_inc;
        3'd4: n_day = day_inc;
        3'd5: begin n_month = mo_inc; n_day = (day > dim_mo) ? dim_mo : day; end
        3'd6: begin n_ylo = ylo_inc; n_day = (day > dim_ylo) ? dim_ylo : day; end
        default: begin n_yhi = yhi_inc; n_day = (day > dim_yhi) ? dim_yhi : day; end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1, s2, s3} <= 3'b000;
      sec     <= 6'd0;
      min     <= 6'd0;
      hour    <= 5'd0;
      day     <= 5'd1;
      month   <= 4'd1;
      year_lo <= 7'd0;
      year_hi <= 7'd20;
    end else begin
      {s1, s2, s3} <= {inc_btn, s1, s2};
      sec     <= n_sec;
      min     <= n_min;
      hour    <= n_hour;
      day     <= n_day;
      month   <= n_month;
      year_lo <= n_ylo;
      year_hi <= n_yhi;
    end
  end
endmodule

// File: tb/tb_clock_calendar.sv
// tb_clock_calendar: random and directed stimulus against a calendar-arithmetic model via a scoreboard queue.
module tb_clock_calendar;
  logic clk = 0, rst = 0, tick_1hz = 0, inc_btn = 0;
  logic [2:0] mode = 3'd0;
  logic [5:0] sec, min;
  logic [4:0] hour, day;
  logic [3:0] month;
  logic [6:0] year_lo, year_hi;
  logic leap;
  clock_calendar dut (.clk(clk), .rst(rst), .tick_1hz(tick_1hz), .mode(mode), .inc_btn(inc_btn),
    .sec(sec), .min(min), .hour(hour), .day(day), .month(month),
    .year_lo(year_lo), .year_hi(year_hi), .leap(leap));
  always #5 clk = ~clk;
  typedef struct packed {int y; int mo; int d; int h; int mi; int s; int l;} st_t;
  st_t q[$];
  st_t exp_st;
  int errors = 0, checks = 0;
  int my = 2000, mmo = 1, md = 1, mh = 0, mmi = 0, ms = 0;
  bit b1 = 0, b2 = 0, b3 = 0;
  function automatic bit lp(int y);
    return (y % 4 == 0 && y % 100 != 0) || y % 400 == 0;
  endfunction
  function automatic int dimf(int mo, int y);
    case (mo)
      2: return lp(y) ? 29 : 28;
      4, 6, 9, 11: return 30;
      default: return 31;
    endcase
  endfunction
  function automatic st_t mst();
    return '{my, mmo, md, mh, mmi, ms, int'(lp(my))};
  endfunction
  function automatic st_t dst();
    return '{int'(year_hi) * 100 + int'(year_lo), int'(month), int'(day), int'(hour),
             int'(min), int'(sec), int'(leap)};
  endfunction
  function automatic string fmt(st_t a);
    return $sformatf("%0d-%0d-%0d %0d:%0d:%0d leap=%0d", a.y, a.mo, a.d, a.h, a.mi, a.s, a.l);
  endfunction
  function automatic int fld(int m);
    case (m)
      1: return ms;
      2: return mmi;
      3: return mh;
      4: return md;
      5: return mmo;
      6: return my % 100;
      default: return my / 100;
    endcase
  endfunction
  function automatic void tick_model();
    ms++;
    if (ms == 60) begin
      ms = 0; mmi++;
      if (mmi == 60) begin
        mmi = 0; mh++;
        if (mh == 24) begin
          mh = 0; md++;
          if (md > dimf(mmo, my)) begin
            md = 1; mmo++;
            if (mmo > 12) begin mmo = 1; my = (my + 1) % 10000; end
          end
        end
      end
    end
  endfunction
  function automatic void edit_model(int m);
    case (m)
      1: ms = (ms + 1) % 60;
      2: mmi = (mmi + 1) % 60;
      3: mh = (mh + 1) % 24;
      4: md = md % dimf(mmo, my) + 1;
      5: mmo = mmo % 12 + 1;
      6: my = (my / 100) * 100 + (my % 100 + 1) % 100;
      default: my = ((my / 100 + 1) % 100) * 100 + my % 100;
    endcase
    if (md > dimf(mmo, my)) md = dimf(mmo, my);
  endfunction
  // button edge takes effect two edges after it is first sampled
  function automatic void model_edge(bit r, bit t, int m, bit b);
    bit p = b2 & ~b3;
    if (r) begin
      my = 2000; mmo = 1; md = 1; mh = 0; mmi = 0; ms = 0;
      b1 = 0; b2 = 0; b3 = 0;
    end else begin
      if (m == 0) begin
        if (t) tick_model();
      end else if (p) edit_model(m);
      b3 = b2; b2 = b1; b1 = b;
    end
  endfunction
  task automatic step(input bit r, input bit t, input int m, input bit b);
    @(negedge clk);
    rst = r; tick_1hz = t; mode = 3'(m); inc_btn = b;
    model_edge(r, t, m, b);
    q.push_back(mst());
    @(posedge clk);
  endtask
  task automatic press(input int m);
    step(0, 0, m, 1);
    repeat (3) step(0, 0, m, 0);
  endtask
  task automatic set_field(input int m, input int target);
    for (int i = 0; i < 130 && fld(m) != target; i++) press(m);
    checks++;
    if (fld(m) != target) begin
      errors++;
      $display("FAIL set_field mode=%0d: got %0d want %0d", m, fld(m), target);
    end
  endtask
  task automatic expect_now(input string nm, input st_t w);
    #2;
    checks++;
    if (dst() != w) begin
      errors++;
      $display("FAIL %s: got %s want %s", nm, fmt(dst()), fmt(w));
    end
  endtask
  task automatic set_hms(input int h, input int mi, input int s);
    set_field(3, h); set_field(2, mi); set_field(1, s);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_st = q.pop_front();
      checks++;
      if (dst() != exp_st) begin
        errors++;
        $display("FAIL scoreboard @%0t: got %s want %s", $time, fmt(dst()), fmt(exp_st));
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    expect_now("reset", '{2000, 1, 1, 0, 0, 0, 1});
    set_hms(23, 59, 59); set_field(5, 12); set_field(4, 31); set_field(6, 99);
    step(0, 1, 0, 0);
    expect_now("rollover_2100", '{2100, 1, 1, 0, 0, 0, 0});
    step(1, 0, 0, 0);
    set_field(5, 2); set_field(4, 28); set_hms(23, 59, 59);
    step(0, 1, 0, 0);
    expect_now("feb28_2000", '{2000, 2, 29, 0, 0, 0, 1});
    set_field(7, 21); set_field(4, 28); set_hms(23, 59, 59);
    step(0, 1, 0, 0);
    expect_now("feb28_2100", '{2100, 3, 1, 0, 0, 0, 0});
    step(1, 0, 0, 0);
    set_field(6, 1); set_field(4, 31); press(5);
    expect_now("mo_clamp_2001", '{2001, 2, 28, 0, 0, 0, 0});
    step(1, 0, 0, 0);
    set_field(6, 4); set_field(4, 31); press(5);
    expect_now("mo_clamp_2004", '{2004, 2, 29, 0, 0, 0, 1});
    step(1, 0, 0, 0);
    set_field(1, 10);
    repeat (20) step(0, 1, 1, 0);
    expect_now("ss_frozen", '{2000, 1, 1, 0, 0, 10, 1});
    step(0, 0, 1, 1); step(0, 0, 1, 1);
    expect_now("inc_edge2", '{2000, 1, 1, 0, 0, 10, 1});
    step(0, 0, 1, 1);
    expect_now("inc_edge3", '{2000, 1, 1, 0, 0, 11, 1});
    repeat (7) step(0, 0, 1, 1);
    repeat (3) step(0, 0, 1, 0);
    expect_now("inc_once", '{2000, 1, 1, 0, 0, 11, 1});
    set_hms(23, 59, 59);
    step(1, 1, 0, 0);
    expect_now("rst_over_tick", '{2000, 1, 1, 0, 0, 0, 1});
    step(0, 0, 1, 1); step(0, 0, 1, 1);
    expect_now("no_pulse_after_rst", '{2000, 1, 1, 0, 0, 0, 1});
    repeat (3) step(0, 0, 1, 0);
    set_hms(23, 59, 40);
    for (int i = 0; i < 1500; i++) begin
      automatic int m = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7);
      repeat ($urandom_range(1, 6))
        step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, m, $urandom_range(0, 1));
    end
    step(0, 0, 0, 0);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clock_calendar.md
CLOCK_CALENDAR -- requirements
Module: clock_calendar

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port tick_1hz, input, 1 bit: one-clk-wide pulse, once per second, synchronous to clk.
REQ-004 SHALL have port mode, input, 3 bits, from the mode FSM: 000 NORMAL, 001 SS, 010 MI, 011 HH, 100 DD, 101 MO, 110 YY (year low digits), 111 YY2 (year high digits).
REQ-005 SHALL have port inc_btn, input, 1 bit: debounced increment button level, asynchronous to clk, active-high.
REQ-006 SHALL have port sec, output, 6 bits: seconds, range 0..59.
REQ-007 SHALL have port min, output, 6 bits: minutes, range 0..59.
REQ-008 SHALL have port hour, output, 5 bits: hours, range 0..23.
REQ-009 SHALL have port day, output, 5 bits: day of month, range 1..dim, where dim is days in the current month.
REQ-010 SHALL have port month, output, 4 bits: month, range 1..12.
REQ-011 SHALL have port year_lo, output, 7 bits: year mod 100, range 0..99.
REQ-012 SHALL have port year_hi, output, 7 bits: year / 100, range 0..99.
REQ-013 SHALL have port leap, output, 1 bit: high when the current year is a leap year; combinational from the year registers.

Function
REQ-014 SHALL pass inc_btn through a 2-flop synchronizer followed by a third delay flop; inc_pulse = sync2 & ~sync3.
REQ-015 SHALL apply an edit increment at the edge on which inc_pulse is high: the field changes on the 3rd rising edge after inc_btn rises.
REQ-016 SHALL produce exactly one inc_pulse per rising edge of inc_btn, regardless of how long inc_btn stays high.
REQ-017 SHALL compute leap = (year_lo != 0 && year_lo[1:0] == 0) || (year_lo == 0 && year_hi[1:0] == 0).
REQ-018 SHALL use dim = 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; 29 for month 2 when leap=1; otherwise 28.
REQ-019 SHALL, in NORMAL when tick_1hz=1, advance sec with a ripple carry in a single cycle: sec 59->0 carries min; min 59->0 carries hour; hour 23->0 carries day; day==dim ->1 carries month; month 12->1 carries year_lo; year_lo 99->0 carries year_hi; year_hi 99->0.
REQ-020 SHALL, in NORMAL, ignore inc_pulse.
REQ-021 SHALL, in any edit mode (001..111), ignore tick_1hz; time is frozen.
REQ-022 SHALL, in an edit mode on inc_pulse, increment only the selected field by 1 with wrap inside its own range and no carry: sec/min 59->0, hour 23->0, day dim->1, month 12->1, year_lo/year_hi 99->0.
REQ-023 SHALL, when a MO, YY or YY2 increment makes day > new dim, load day with the new dim in the same update.
REQ-024 SHALL use the mode value sampled at the edge in question; a mode change and a tick_1hz in the same cycle are resolved by the pre-edge mode value.
REQ-025 SHALL use no arithmetic wider than each field; all compares are against constants or dim.

Reset
REQ-026 SHALL, at the edge where rst=1, set sec=0, min=0, hour=0, day=1, month=1, year_lo=0, year_hi=20 (2000-01-01 00:00:00; leap=1), and clear all synchronizer flops.
REQ-027 SHALL give rst priority over tick_1hz and inc_pulse in the same cycle; a carry in progress is discarded.
REQ-028 SHALL not generate an inc_pulse in the first two cycles after reset release, even with inc_btn held high.

Verification
REQ-029 SHALL cover: rst held 2 cycles -> 00:00:00 01/01/2000, leap=1.
REQ-030 SHALL cover: fields edited to 23:59:59 31/12/2099, mode=NORMAL, one tick -> 00:00:00 01/01/2100, leap=0.
REQ-031 SHALL cover: 23:59:59 28/02/2000 + tick -> 29/02/2000; 23:59:59 28/02/2100 + tick -> 01/03/2100.
REQ-032 SHALL cover: mode=MO, day=31, month=1, year 2001, one inc -> month=2, day=28; with year 2004 -> day=29.
REQ-033 SHALL cover: mode=SS, sec=10, tick every cycle for 20 cycles -> sec stays 10; inc_btn held for 10 cycles -> sec=11 exactly, changing on the 3rd edge.
REQ-034 SHALL cover: rst asserted in the same cycle as a tick at 23:59:59 -> reset values, with no carry visible.
